// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-ported register file.
// Every regfile_mp file imports this package.
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_NUM_WR   = 2;
   localparam int ZERO_REG     = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between the pipeline and the register file.
// Decode and writeback use the master modport; the register file uses the slave modport.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR
) ();

   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*AW-1:0]     wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     iss_en;
   logic [AW-1:0]            iss_addr;
   logic [NUM_REGS-1:0]      busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard with one busy bit per register.
// An issue sets a bit and a write clears it. When both hit the same register in one cycle, the set wins.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en_i,
   input  logic [AW-1:0]        set_addr_i,
   input  logic [NUM_WR-1:0]    clr_en_i,
   input  logic [NUM_WR*AW-1:0] clr_addr_i,
   output logic [NUM_REGS-1:0]  busy_vec_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // The set is applied after the clears so a new producer supersedes the retiring one.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (clr_en_i[j]) begin
            busy_d[clr_addr_i[j*AW +: AW]] = 1'b0;
         end
      end
      if (set_en_i) begin
         busy_d[set_addr_i] = 1'b1;
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with a hardwired-zero r0 and a same-cycle write-to-read bypass.
// It also produces per-port busy flags from the pending-write scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);

   localparam int            AW        = $clog2(NUM_REGS);
   localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

   logic [DATA_W-1:0]        bank_q [NUM_REGS];
   logic [DATA_W-1:0]        bank_d [NUM_REGS];
   logic [NUM_REGS-1:0]      busyVec;
   logic [NUM_RD*DATA_W-1:0] rdDataAll;
   logic [NUM_RD-1:0]        rdBusyAll;

   // Ports are scanned in ascending order, so the highest-index port wins a collision.
   always_comb begin
      bank_d = bank_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != ZERO_ADDR)) begin
            bank_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            bank_q[r] <= '0;
         end
      end else begin
         bank_q <= bank_d;
      end
   end

   // The bypass uses the same ascending scan as the write decode, so both agree on which port wins.
   always_comb begin : readMux
      logic [AW-1:0]     addr;
      logic              hit;
      logic [DATA_W-1:0] byp;
      addr      = '0;
      hit       = 1'b0;
      byp       = '0;
      rdDataAll = '0;
      rdBusyAll = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         addr = bus.rd_addr[i*AW +: AW];
         hit  = 1'b0;
         byp  = '0;
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == addr)) begin
               hit = 1'b1;
               byp = bus.wr_data[j*DATA_W +: DATA_W];
            end
         end
         if (!rst && (addr != ZERO_ADDR)) begin
            rdDataAll[i*DATA_W +: DATA_W] = hit ? byp : bank_q[addr];
            rdBusyAll[i]                  = busyVec[addr] & ~hit;
         end
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .AW       (AW)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_en_i   (bus.iss_en),
      .set_addr_i (bus.iss_addr),
      .clr_en_i   (bus.wr_en),
      .clr_addr_i (bus.wr_addr),
      .busy_vec_o (busyVec)
   );

   assign bus.rd_data  = rdDataAll;
   assign bus.rd_busy  = rdBusyAll;
   assign bus.busy_vec = busyVec;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp in two configurations: the default build, and a wide build with 64-bit data, 64 registers, 4 read ports and 3 write ports.
// Directed vectors and random traffic are both checked against a behavioural model.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // Per-DUT configuration: index 0 is the default build, index 1 is the wide build.
   int nRd   [2] = '{2, 4};
   int nWr   [2] = '{2, 3};
   int nRegs [2] = '{32, 64};

   logic [5:0]  rdAddr  [2][4];
   logic        wrEn    [2][3];
   logic [5:0]  wrAddr  [2][3];
   logic [63:0] wrData  [2][3];
   logic        issEn   [2];
   logic [5:0]  issAddr [2];
   logic [63:0] rdData  [2][4];
   logic        rdBusy  [2][4];
   logic [63:0] busyVec [2];

   logic [63:0] mReg  [2][64];
   logic        mBusy [2][64];

   int checkCount = 0;
   int passCount  = 0;

   regfile_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) ifA ();
   regfile_mp_if #(.DATA_W(64), .NUM_REGS(64), .NUM_RD(4), .NUM_WR(3)) ifB ();

   regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (ifA.slave)
   );

   regfile_mp #(.DATA_W(64), .NUM_REGS(64), .NUM_RD(4), .NUM_WR(3)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (ifB.slave)
   );

   for (genvar i = 0; i < 2; i++) begin : gArd
      assign ifA.rd_addr[i*5 +: 5] = rdAddr[0][i][4:0];
      assign rdData[0][i]          = {32'h0, ifA.rd_data[i*32 +: 32]};
      assign rdBusy[0][i]          = ifA.rd_busy[i];
   end
   for (genvar i = 2; i < 4; i++) begin : gArdUnused
      assign rdData[0][i] = '0;
      assign rdBusy[0][i] = 1'b0;
   end
   for (genvar j = 0; j < 2; j++) begin : gAwr
      assign ifA.wr_en[j]          = wrEn[0][j];
      assign ifA.wr_addr[j*5 +: 5] = wrAddr[0][j][4:0];
      assign ifA.wr_data[j*32 +: 32] = wrData[0][j][31:0];
   end
   assign ifA.iss_en   = issEn[0];
   assign ifA.iss_addr = issAddr[0][4:0];
   assign busyVec[0]   = {32'h0, ifA.busy_vec};

   for (genvar i = 0; i < 4; i++) begin : gBrd
      assign ifB.rd_addr[i*6 +: 6] = rdAddr[1][i];
      assign rdData[1][i]          = ifB.rd_data[i*64 +: 64];
      assign rdBusy[1][i]          = ifB.rd_busy[i];
   end
   for (genvar j = 0; j < 3; j++) begin : gBwr
      assign ifB.wr_en[j]            = wrEn[1][j];
      assign ifB.wr_addr[j*6 +: 6]   = wrAddr[1][j];
      assign ifB.wr_data[j*64 +: 64] = wrData[1][j];
   end
   assign ifB.iss_en   = issEn[1];
   assign ifB.iss_addr = issAddr[1];
   assign busyVec[1]   = ifB.busy_vec;

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        ie;
      logic [4:0]  ia;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] ed0;
      logic [31:0] ed1;
      logic        eb0;
      logic        eb1;
      int          vIdx;
      logic        eV;
   } vec_t;

   vec_t vecs [16];

   function automatic logic [63:0] dMask(input int d);
      return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   // Model view of a read: r0 and reset read as zero; otherwise the highest-index write to the same address this cycle is forwarded.
   task automatic expRead(input int d, input int i, output logic [63:0] ed, output logic eb);
      int a;
      a  = int'(rdAddr[d][i]);
      ed = '0;
      eb = 1'b0;
      if (!rst && a != 0) begin
         ed = mReg[d][a];
         eb = mBusy[d][a];
         for (int j = 0; j < nWr[d]; j++) begin
            if (wrEn[d][j] && int'(wrAddr[d][j]) == a) begin
               ed = wrData[d][j] & dMask(d);
               eb = 1'b0;
            end
         end
      end
   endtask

   function automatic logic [63:0] expVec(input int d);
      logic [63:0] v;
      v = '0;
      if (!rst) begin
         for (int r = 0; r < nRegs[d]; r++) v[r] = mBusy[d][r];
      end
      return v;
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 64; r++) begin
            mReg[d][r]  = '0;
            mBusy[d][r] = 1'b0;
         end
      end
   endtask

   task automatic modelUpdate();
      for (int d = 0; d < 2; d++) begin
         for (int j = 0; j < nWr[d]; j++) begin
            if (wrEn[d][j] && wrAddr[d][j] != 6'd0) begin
               mReg[d][wrAddr[d][j]]  = wrData[d][j] & dMask(d);
               mBusy[d][wrAddr[d][j]] = 1'b0;
            end
         end
         if (issEn[d] && issAddr[d] != 6'd0) mBusy[d][issAddr[d]] = 1'b1;
      end
   endtask

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic checkOutput(input int d, input string name);
      logic [63:0] ed;
      logic        eb;
      for (int i = 0; i < nRd[d]; i++) begin
         expRead(d, i, ed, eb);
         checkVal($sformatf("%s.rdData%0d", name, i), rdData[d][i], ed);
         checkVal($sformatf("%s.rdBusy%0d", name, i), {63'h0, rdBusy[d][i]}, {63'h0, eb});
      end
      checkVal($sformatf("%s.busyVec", name), busyVec[d], expVec(d));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) modelUpdate();
      #1;
   endtask

   task automatic clearInputs();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) rdAddr[d][i] = '0;
         for (int j = 0; j < 3; j++) begin
            wrEn[d][j]   = 1'b0;
            wrAddr[d][j] = '0;
            wrData[d][j] = '0;
         end
         issEn[d]   = 1'b0;
         issAddr[d] = '0;
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      clearInputs();
      wrEn[0][0]   = v.we0;
      wrAddr[0][0] = {1'b0, v.wa0};
      wrData[0][0] = {32'h0, v.wd0};
      wrEn[0][1]   = v.we1;
      wrAddr[0][1] = {1'b0, v.wa1};
      wrData[0][1] = {32'h0, v.wd1};
      issEn[0]     = v.ie;
      issAddr[0]   = {1'b0, v.ia};
      rdAddr[0][0] = {1'b0, v.ra0};
      rdAddr[0][1] = {1'b0, v.ra1};
   endtask

   // Half the addresses come from r0..r7 so that collisions and bypass hits are frequent.
   function automatic logic [5:0] randAddr(input int d);
      if ($urandom_range(0, 1) == 0) return 6'($urandom_range(0, 7));
      return 6'($urandom_range(0, nRegs[d] - 1));
   endfunction

   task automatic randomStim(input int d);
      clearInputs();
      for (int i = 0; i < nRd[d]; i++) rdAddr[d][i] = randAddr(d);
      for (int j = 0; j < nWr[d]; j++) begin
         wrEn[d][j]   = ($urandom_range(0, 1) == 1);
         wrAddr[d][j] = randAddr(d);
         wrData[d][j] = {$urandom, $urandom} & dMask(d);
      end
      issEn[d]   = ($urandom_range(0, 9) < 3);
      issAddr[d] = randAddr(d);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1,5'd3,32'hDEADBEEF, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd3, 32'h0,32'hDEADBEEF, 1'b0,1'b0, 3,1'b0};
      vecs[1]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd3,5'd3, 32'hDEADBEEF,32'hDEADBEEF, 1'b0,1'b0, 3,1'b0};
      vecs[2]  = '{1'b1,5'd9,32'h11, 1'b1,5'd9,32'h22, 1'b0,5'd0, 5'd9,5'd9, 32'h22,32'h22, 1'b0,1'b0, 9,1'b0};
      vecs[3]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd9,5'd9, 32'h22,32'h22, 1'b0,1'b0, 9,1'b0};
      vecs[4]  = '{1'b1,5'd0,32'hFFFFFFFF, 1'b0,5'd0,32'h0, 1'b1,5'd0, 5'd0,5'd0, 32'h0,32'h0, 1'b0,1'b0, 0,1'b0};
      vecs[5]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd0, 32'h0,32'h0, 1'b0,1'b0, 0,1'b0};
      vecs[6]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd4, 5'd4,5'd3, 32'h0,32'hDEADBEEF, 1'b0,1'b0, 4,1'b0};
      vecs[7]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd4, 32'h0,32'h0, 1'b1,1'b1, 4,1'b1};
      vecs[8]  = '{1'b0,5'd0,32'h0, 1'b1,5'd4,32'h55, 1'b0,5'd0, 5'd4,5'd4, 32'h55,32'h55, 1'b0,1'b0, 4,1'b1};
      vecs[9]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd4, 32'h55,32'h55, 1'b0,1'b0, 4,1'b0};
      vecs[10] = '{1'b1,5'd4,32'h66, 1'b0,5'd0,32'h0, 1'b1,5'd4, 5'd4,5'd4, 32'h66,32'h66, 1'b0,1'b0, 4,1'b0};
      vecs[11] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd4, 32'h66,32'h66, 1'b1,1'b1, 4,1'b1};
      vecs[12] = '{1'b1,5'd10,32'h77, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd10,5'd4, 32'h77,32'h66, 1'b0,1'b1, 10,1'b0};
      vecs[13] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd10,5'd4, 32'h77,32'h66, 1'b0,1'b1, 10,1'b0};
      vecs[14] = '{1'b1,5'd4,32'h88, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd9, 32'h88,32'h22, 1'b0,1'b0, 4,1'b1};
      vecs[15] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd9, 32'h88,32'h22, 1'b0,1'b0, 4,1'b0};

      rst = 1'b1;
      clearInputs();
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput(0, "rstA");
      checkOutput(1, "rstB");
      rst = 1'b0;

      for (int k = 0; k < 16; k++) begin
         applyStimulus(vecs[k]);
         #1;
         checkVal($sformatf("vec%0d.rd0", k), rdData[0][0], {32'h0, vecs[k].ed0});
         checkVal($sformatf("vec%0d.rd1", k), rdData[0][1], {32'h0, vecs[k].ed1});
         checkVal($sformatf("vec%0d.busy0", k), {63'h0, rdBusy[0][0]}, {63'h0, vecs[k].eb0});
         checkVal($sformatf("vec%0d.busy1", k), {63'h0, rdBusy[0][1]}, {63'h0, vecs[k].eb1});
         checkVal($sformatf("vec%0d.vecBit", k), {63'h0, busyVec[0][vecs[k].vIdx]}, {63'h0, vecs[k].eV});
         tick();
      end

      // Async reset while r5 holds data and r7 is reserved.
      clearInputs();
      wrEn[0][0] = 1'b1; wrAddr[0][0] = 6'd5; wrData[0][0] = 64'h1234;
      tick();
      clearInputs();
      issEn[0] = 1'b1; issAddr[0] = 6'd7;
      tick();
      clearInputs();
      rdAddr[0][0] = 6'd5; rdAddr[0][1] = 6'd7;
      #1;
      checkVal("preRst.r5", rdData[0][0], 64'h1234);
      checkVal("preRst.busy7", {63'h0, rdBusy[0][1]}, 64'h1);
      #1;
      rst = 1'b1;
      modelReset();
      wrEn[0][0] = 1'b1; wrAddr[0][0] = 6'd5; wrData[0][0] = 64'hBAD;
      #1;
      checkVal("rstAsync.r5", rdData[0][0], 64'h0);
      checkVal("rstAsync.vec", busyVec[0], 64'h0);
      checkOutput(0, "rstAsync");
      tick();
      rst = 1'b0;
      clearInputs();
      rdAddr[0][0] = 6'd5;
      #1;
      checkVal("postRst.r5", rdData[0][0], 64'h0);
      wrEn[0][1] = 1'b1; wrAddr[0][1] = 6'd6; wrData[0][1] = 64'hABC;
      tick();
      clearInputs();
      rdAddr[0][0] = 6'd6;
      #1;
      checkVal("postRst.r6", rdData[0][0], 64'hABC);
      checkOutput(0, "postRst");

      // Wide build: write port 2 to r63, read on all four ports.
      clearInputs();
      wrEn[1][2] = 1'b1; wrAddr[1][2] = 6'd63; wrData[1][2] = 64'hCAFE_F00D_1234_5678;
      for (int i = 0; i < 4; i++) rdAddr[1][i] = 6'd63;
      #1;
      for (int i = 0; i < 4; i++) checkVal($sformatf("b63byp%0d", i), rdData[1][i], 64'hCAFE_F00D_1234_5678);
      checkOutput(1, "b63");
      tick();
      wrEn[1][2] = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) checkVal($sformatf("b63hold%0d", i), rdData[1][i], 64'hCAFE_F00D_1234_5678);

      clearInputs();
      for (int j = 0; j < 3; j++) begin
         wrEn[1][j] = 1'b1; wrAddr[1][j] = 6'd9; wrData[1][j] = 64'h1111_0000_0000_0000 * 64'(j + 1);
      end
      for (int i = 0; i < 4; i++) rdAddr[1][i] = 6'd9;
      #1;
      checkVal("bColl.byp", rdData[1][3], 64'h3333_0000_0000_0000);
      tick();
      for (int j = 0; j < 3; j++) wrEn[1][j] = 1'b0;
      #1;
      checkVal("bColl.stored", rdData[1][0], 64'h3333_0000_0000_0000);

      clearInputs();
      wrEn[1][1] = 1'b1; wrAddr[1][1] = 6'd0; wrData[1][1] = '1;
      issEn[1] = 1'b1; issAddr[1] = 6'd0;
      #1;
      checkVal("bZero.rd", rdData[1][0], 64'h0);
      tick();
      clearInputs();
      #1;
      checkVal("bZero.vec0", {63'h0, busyVec[1][0]}, 64'h0);
      checkVal("bZero.busy", {63'h0, rdBusy[1][2]}, 64'h0);

      issEn[1] = 1'b1; issAddr[1] = 6'd40;
      rdAddr[1][1] = 6'd40;
      #1;
      checkVal("bIss.same", {63'h0, rdBusy[1][1]}, 64'h0);
      tick();
      issEn[1] = 1'b0;
      #1;
      checkVal("bIss.next", {63'h0, rdBusy[1][1]}, 64'h1);
      wrEn[1][1] = 1'b1; wrAddr[1][1] = 6'd40; wrData[1][1] = 64'h55;
      #1;
      checkVal("bWr.busy", {63'h0, rdBusy[1][1]}, 64'h0);
      checkVal("bWr.data", rdData[1][1], 64'h55);
      tick();

      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
               rst = 1'b1;
               modelReset();
               #1;
               checkOutput(d, "rndRst");
               tick();
               rst = 1'b0;
            end
            randomStim(d);
            #1;
            checkOutput(d, $sformatf("rnd%0d_%0d", d, n));
            tick();
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
